// File: rtl/ata_pio_engine_if.sv
// Host-side and ATA-side signal bundle for the PIO engine.
// The engine connects through the slave modport; the host/device model uses master.
interface ata_pio_engine_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = 1
) ();
  logic              TSn;
  logic              ATA_ENn;
  logic              RnW;
  logic [CH_W-1:0]   CH_SEL;
  logic              REG_SEL;
  logic [NUM_CH-1:0] FAST;
  logic [NUM_CH-1:0] IORDY;
  logic [NUM_CH-1:0] CS0n;
  logic [NUM_CH-1:0] CS1n;
  logic [NUM_CH-1:0] DIORn;
  logic [NUM_CH-1:0] DIOWn;
  logic              ATA_LATCH;
  logic              ATA_TACK;
  logic              ATA_TEA;
  logic              BUSY;

  modport master (
    output TSn, ATA_ENn, RnW, CH_SEL, REG_SEL, FAST, IORDY,
    input  CS0n, CS1n, DIORn, DIOWn, ATA_LATCH, ATA_TACK, ATA_TEA, BUSY
  );

  modport slave (
    input  TSn, ATA_ENn, RnW, CH_SEL, REG_SEL, FAST, IORDY,
    output CS0n, CS1n, DIORn, DIOWn, ATA_LATCH, ATA_TACK, ATA_TEA, BUSY
  );
endinterface

// File: rtl/ata_pio_engine.sv
// Multi-channel ATA PIO cycle engine: SETUP/ACTIVE/WAIT/HOLD/RECOV sequencing with
// per-channel PIO0/PIO4 timing, IORDY wait states and timeout abort. All outputs registered.
module ata_pio_engine #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned CH_W          = 1,
  parameter int unsigned SLOW_SETUP    = 3,
  parameter int unsigned SLOW_ACTIVE   = 7,
  parameter int unsigned SLOW_HOLD     = 1,
  parameter int unsigned SLOW_RECOV    = 13,
  parameter int unsigned FAST_SETUP    = 1,
  parameter int unsigned FAST_ACTIVE   = 3,
  parameter int unsigned FAST_HOLD     = 1,
  parameter int unsigned FAST_RECOV    = 0,
  parameter int unsigned IORDY_TIMEOUT = 1250
) (
  input logic              CLK40,
  input logic              RESET,
  ata_pio_engine_if.slave  bus
);

  function automatic int unsigned max2(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MaxLen = max2(max2(max2(SLOW_SETUP, SLOW_ACTIVE),
                                             max2(SLOW_HOLD, SLOW_RECOV)),
                                        max2(max2(FAST_SETUP, FAST_ACTIVE),
                                             max2(max2(FAST_HOLD, FAST_RECOV), IORDY_TIMEOUT)));
  localparam int unsigned CntW = $clog2(MaxLen + 1);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t CntOne = cnt_t'(1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSetup  = 3'd1;
  localparam logic [2:0] StActive = 3'd2;
  localparam logic [2:0] StWait   = 3'd3;
  localparam logic [2:0] StHold   = 3'd4;
  localparam logic [2:0] StRecov  = 3'd5;

  function automatic cnt_t phase_len(logic [2:0] st, logic fast);
    case (st)
      StSetup:  return fast ? cnt_t'(FAST_SETUP)  : cnt_t'(SLOW_SETUP);
      StActive: return fast ? cnt_t'(FAST_ACTIVE) : cnt_t'(SLOW_ACTIVE);
      StHold:   return fast ? cnt_t'(FAST_HOLD)   : cnt_t'(SLOW_HOLD);
      StRecov:  return fast ? cnt_t'(FAST_RECOV)  : cnt_t'(SLOW_RECOV);
      StWait:   return cnt_t'(IORDY_TIMEOUT);
      default:  return '0;
    endcase
  endfunction

  function automatic logic [2:0] next_phase(logic [2:0] st);
    case (st)
      StSetup:  return StActive;
      StActive: return StHold;
      StHold:   return StRecov;
      default:  return StIdle;
    endcase
  endfunction

  logic [2:0]        state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              reg_q, reg_d, rnw_q, rnw_d, fast_q, fast_d, exit_q, exit_d;
  logic [NUM_CH-1:0] cs0n_q, cs0n_d, cs1n_q, cs1n_d, diorn_q, diorn_d, diown_q, diown_d;
  logic              latch_q, latch_d, tack_q, tack_d, tea_q, tea_d, busy_q, busy_d;
  logic              sel_d, strb_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    reg_d   = reg_q;
    rnw_d   = rnw_q;
    fast_d  = fast_q;
    exit_d  = 1'b0;
    tea_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (!bus.TSn && !bus.ATA_ENn) begin
          ch_d  = bus.CH_SEL;
          reg_d = bus.REG_SEL;
          rnw_d = bus.RnW;
          if (32'(bus.CH_SEL) >= NUM_CH) begin
            tea_d = 1'b1;
          end else begin
            fast_d  = bus.FAST[bus.CH_SEL];
            state_d = StSetup;
            cnt_d   = phase_len(StSetup, fast_d);
          end
        end
      end
      StSetup, StActive, StHold, StRecov: begin
        if (cnt_q == CntOne) begin
          state_d = next_phase(state_q);
          cnt_d   = phase_len(state_d, fast_q);
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StWait: begin
        // exit_q marks the one extra strobe-low cycle after IORDY was seen high
        if (exit_q) begin
          state_d = StHold;
          cnt_d   = phase_len(StHold, fast_q);
        end else if (bus.IORDY[ch_q]) begin
          exit_d = 1'b1;
        end else if (cnt_q == CntOne) begin
          tea_d   = 1'b1;
          state_d = StRecov;
          cnt_d   = phase_len(StRecov, fast_q);
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StRecov && cnt_d == '0) begin
      state_d = StIdle;
    end
    // IORDY is checked on the edge entering the final strobe cycle so LATCH can be registered
    if (state_d == StActive && cnt_d == CntOne && !bus.IORDY[ch_q]) begin
      state_d = StWait;
      cnt_d   = phase_len(StWait, fast_q);
    end
  end

  always_comb begin
    busy_d  = (state_d != StIdle);
    sel_d   = (state_d == StSetup) || (state_d == StActive) || (state_d == StWait) ||
              (state_d == StHold);
    strb_d  = (state_d == StActive) || (state_d == StWait);
    latch_d = rnw_d && (((state_d == StActive) && (cnt_d == CntOne)) || exit_d);
    tack_d  = (state_d == StHold) && (state_q != StHold);
    cs0n_d  = '1;
    cs1n_d  = '1;
    diorn_d = '1;
    diown_d = '1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_d == CH_W'(i)) begin
        cs0n_d[i]  = !(sel_d && !reg_d);
        cs1n_d[i]  = !(sel_d && reg_d);
        diorn_d[i] = !(strb_d && rnw_d);
        diown_d[i] = !(strb_d && !rnw_d);
      end
    end
  end

  always_ff @(posedge CLK40 or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ch_q    <= '0;
      reg_q   <= 1'b0;
      rnw_q   <= 1'b0;
      fast_q  <= 1'b0;
      exit_q  <= 1'b0;
      cs0n_q  <= '1;
      cs1n_q  <= '1;
      diorn_q <= '1;
      diown_q <= '1;
      latch_q <= 1'b0;
      tack_q  <= 1'b0;
      tea_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      reg_q   <= reg_d;
      rnw_q   <= rnw_d;
      fast_q  <= fast_d;
      exit_q  <= exit_d;
      cs0n_q  <= cs0n_d;
      cs1n_q  <= cs1n_d;
      diorn_q <= diorn_d;
      diown_q <= diown_d;
      latch_q <= latch_d;
      tack_q  <= tack_d;
      tea_q   <= tea_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.CS0n      = cs0n_q;
  assign bus.CS1n      = cs1n_q;
  assign bus.DIORn     = diorn_q;
  assign bus.DIOWn     = diown_q;
  assign bus.ATA_LATCH = latch_q;
  assign bus.ATA_TACK  = tack_q;
  assign bus.ATA_TEA   = tea_q;
  assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_ata_pio_engine.sv
// Bench for ata_pio_engine: per-cycle expected waveforms built from the phase-length rules,
// compared every cycle, plus literal cycle counts for the headline transfers.
module tb_ata_pio_engine;
  localparam int NCh     = 3;
  localparam int ChW     = 2;
  localparam int Timeout = 1250;
  localparam int Depth   = 2048;
  localparam int SlowS = 3, SlowA = 7, SlowH = 1, SlowR = 13;
  localparam int FastS = 1, FastA = 3, FastH = 1, FastR = 0;

  typedef struct packed {
    logic [2:0] cs0n;
    logic [2:0] cs1n;
    logic [2:0] diorn;
    logic [2:0] diown;
    logic       latch;
    logic       tack;
    logic       tea;
    logic       busy;
  } out_t;
  localparam out_t IdleV = 16'hFFF0;

  logic clk = 1'b0;
  logic rst;
  ata_pio_engine_if #(.NUM_CH(NCh), .CH_W(ChW)) bus ();
  ata_pio_engine #(.NUM_CH(NCh), .CH_W(ChW)) dut (.CLK40(clk), .RESET(rst), .bus(bus));

  always #5 clk = ~clk;

  out_t       exp_v      [Depth];
  logic [2:0] iordy_plan [Depth];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int m_busy = 0, m_cs = 0, m_strb = 0, m_latch = 0, m_tack = 0, m_tea = 0;
  int b_busy, b_cs, b_strb, b_latch, b_tack, b_tea;

  assign bus.IORDY = iordy_plan[cyc];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Compare this cycle's outputs at the falling edge, then advance to just after the rising edge.
  task automatic tick();
    out_t act;
    @(negedge clk);
    act = {bus.CS0n, bus.CS1n, bus.DIORn, bus.DIOWn,
           bus.ATA_LATCH, bus.ATA_TACK, bus.ATA_TEA, bus.BUSY};
    tests++;
    if (act !== exp_v[cyc]) begin
      fails++;
      $display("FAIL cycle %0d outputs: got %h want %h", cyc, act, exp_v[cyc]);
    end
    m_busy  += int'(act.busy);
    m_cs    += ((act.cs0n != 3'b111) || (act.cs1n != 3'b111)) ? 1 : 0;
    m_strb  += ((act.diorn != 3'b111) || (act.diown != 3'b111)) ? 1 : 0;
    m_latch += int'(act.latch);
    m_tack  += int'(act.tack);
    m_tea   += int'(act.tea);
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= Depth - 1) begin
      $display("FAIL cycle budget exhausted at %0d", cyc);
      $fatal(1, "cycle budget");
    end
  endtask

  // Expected outputs of one transfer whose first busy cycle is c0. ext = extra strobe cycles
  // from IORDY wait states; tmo = IORDY never returns. IORDY is looked at on the edge that
  // enters the final strobe cycle, so the low window starts one cycle before it.
  task automatic plan(input int c0, input bit f, input bit rd, input int ch, input bit rs,
                      input int ext, input bit tmo, output int last);
    int s, a, h, r, nstrb, strb0, rec0;
    out_t v;
    s = f ? FastS : SlowS;
    a = f ? FastA : SlowA;
    h = f ? FastH : SlowH;
    r = f ? FastR : SlowR;
    if (ch >= NCh) begin
      v = exp_v[c0]; v.tea = 1'b1; exp_v[c0] = v;
      last = c0;
      return;
    end
    nstrb = tmo ? (a - 1 + Timeout) : (a + ext);
    strb0 = c0 + s;
    rec0  = tmo ? (strb0 + nstrb) : (strb0 + nstrb + h);
    for (int c = c0; c < rec0 + r; c++) begin
      v = exp_v[c];
      v.busy = 1'b1;
      if (c < rec0) begin
        if (rs) v.cs1n[ch] = 1'b0;
        else    v.cs0n[ch] = 1'b0;
      end
      if (c >= strb0 && c < strb0 + nstrb) begin
        if (rd) v.diorn[ch] = 1'b0;
        else    v.diown[ch] = 1'b0;
      end
      if (!tmo && rd && c == strb0 + nstrb - 1) v.latch = 1'b1;
      if (!tmo && c == strb0 + nstrb) v.tack = 1'b1;
      exp_v[c] = v;
    end
    if (tmo) begin
      v = exp_v[rec0]; v.tea = 1'b1; exp_v[rec0] = v;
    end
    last = (tmo && r == 0) ? rec0 : rec0 + r - 1;
    if (tmo || ext > 0) begin
      for (int k = 0; k < (tmo ? Timeout + 4 : ext); k++) iordy_plan[strb0 + a - 2 + k][ch] = 1'b0;
    end
  endtask

  task automatic snap();
    b_busy = m_busy; b_cs = m_cs; b_strb = m_strb;
    b_latch = m_latch; b_tack = m_tack; b_tea = m_tea;
  endtask

  task automatic check_meas(input string tag, input int busy, input int cs, input int strb,
                            input int latch, input int tack, input int tea);
    check({tag, "_busy_cycles"}, m_busy - b_busy, busy);
    check({tag, "_cs_cycles"}, m_cs - b_cs, cs);
    check({tag, "_strobe_cycles"}, m_strb - b_strb, strb);
    check({tag, "_latch_pulses"}, m_latch - b_latch, latch);
    check({tag, "_tack_pulses"}, m_tack - b_tack, tack);
    check({tag, "_tea_pulses"}, m_tea - b_tea, tea);
  endtask

  // One transfer; while busy, TSn is held low and the selects/timing inputs are scrambled.
  task automatic run_xfer(input bit rd, input int ch, input bit rs, input int ext, input bit tmo);
    int last_c;
    logic [2:0] fsave;
    bit f;
    fsave = bus.FAST;
    f = (ch < NCh) ? fsave[ch] : 1'b0;
    bus.TSn = 1'b0; bus.ATA_ENn = 1'b0; bus.RnW = rd;
    bus.CH_SEL = ch[ChW-1:0]; bus.REG_SEL = rs;
    plan(cyc + 1, f, rd, ch, rs, ext, tmo, last_c);
    snap();
    tick();
    if (ch < NCh) begin
      bus.CH_SEL = ~bus.CH_SEL; bus.REG_SEL = ~rs; bus.RnW = ~rd; bus.FAST = ~fsave;
    end else begin
      bus.TSn = 1'b1; bus.ATA_ENn = 1'b1;
    end
    tick();
    bus.TSn = 1'b1; bus.ATA_ENn = 1'b1; bus.FAST = fsave; bus.CH_SEL = '0; bus.REG_SEL = 1'b0;
    while (cyc <= last_c + 2) tick();
  endtask

  initial begin
    int last_c;
    rst = 1'b1;
    bus.TSn = 1'b1; bus.ATA_ENn = 1'b1; bus.RnW = 1'b1;
    bus.CH_SEL = '0; bus.REG_SEL = 1'b0; bus.FAST = 3'b001;
    for (int i = 0; i < Depth; i++) begin
      exp_v[i] = IdleV;
      iordy_plan[i] = 3'b111;
    end
    @(posedge clk);
    #1;
    check("reset_cs0n", bus.CS0n, 7);
    check("reset_dioRn", bus.DIORn, 7);
    check("reset_busy", bus.BUSY, 0);
    repeat (3) tick();

    // Fast read ch0 issued in the same cycle reset drops: accepted on the next edge.
    rst = 1'b0;
    run_xfer(1'b1, 0, 1'b0, 0, 1'b0);
    check_meas("fast_read", 5, 5, 3, 1, 1, 0);

    // Slow write ch1, control block.
    run_xfer(1'b0, 1, 1'b1, 0, 1'b0);
    check_meas("slow_write", 24, 11, 7, 0, 1, 0);

    // Fast read ch0 with four wait states.
    run_xfer(1'b1, 0, 1'b0, 4, 1'b0);
    check_meas("wait_read", 9, 9, 7, 1, 1, 0);

    // Fast write ch2 once FAST[2] is set.
    bus.FAST = 3'b101;
    tick();
    run_xfer(1'b0, 2, 1'b0, 0, 1'b0);
    check_meas("fast_write_ch2", 5, 5, 3, 0, 1, 0);
    bus.FAST = 3'b001;

    // Nonexistent channel: error pulse only.
    run_xfer(1'b1, 3, 1'b0, 0, 1'b0);
    check_meas("bad_channel", 0, 0, 0, 0, 0, 1);

    // TSn without address decode does nothing.
    snap();
    bus.TSn = 1'b0; bus.ATA_ENn = 1'b1;
    tick();
    bus.TSn = 1'b1;
    repeat (3) tick();
    check_meas("no_decode", 0, 0, 0, 0, 0, 0);

    // Slow read ch1 with IORDY stuck low: abort after the timeout.
    run_xfer(1'b1, 1, 1'b0, 0, 1'b1);
    check_meas("iordy_timeout", 3 + 6 + Timeout + 13, 3 + 6 + Timeout, 6 + Timeout, 0, 0, 1);

    // Reset in the middle of ACTIVE.
    bus.TSn = 1'b0; bus.ATA_ENn = 1'b0; bus.RnW = 1'b1; bus.CH_SEL = '0; bus.REG_SEL = 1'b0;
    plan(cyc + 1, 1'b1, 1'b1, 0, 1'b0, 0, 1'b0, last_c);
    tick();
    bus.TSn = 1'b1; bus.ATA_ENn = 1'b1;
    tick();
    tick();
    check("pre_reset_diorn", bus.DIORn, 6);
    #2 rst = 1'b1;
    #1;
    check("midreset_diorn", bus.DIORn, 7);
    check("midreset_cs0n", bus.CS0n, 7);
    check("midreset_busy", bus.BUSY, 0);
    check("midreset_latch", bus.ATA_LATCH, 0);
    for (int c = cyc; c <= last_c; c++) exp_v[c] = IdleV;
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
